// File: rtl/ssd_countdown_monitor.sv
// Decodes a two-digit seven-segment countdown display and tracks its sequence:
// lock, step errors, wrap events and a saturating error count. Define DP_CHECK_EN to treat a lit dp as a code error.
module ssd_countdown_monitor #(
  parameter int START_VAL  = 30,
  parameter int WRAP_VAL   = 29,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       seg_tens,
  input  logic [7:0]       seg_ones,
  input  logic             sample,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             valid,
  output logic             locked,
  output logic             code_err,
  output logic             seq_err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  localparam logic [6:0] START_V = 7'(START_VAL);
  localparam logic [6:0] WRAP_V  = 7'(WRAP_VAL);
  localparam logic [3:0] LOCK_V  = 4'(LOCK_COUNT);

  state_t     state;
  logic [6:0] prev_val;
  logic [3:0] match_cnt;

  // Returns {legal, digit}; segments are active-low with a at the MSB.
  function automatic logic [4:0] decode_digit(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = {1'b1, 4'd0};
      7'b1001111: r = {1'b1, 4'd1};
      7'b0010010: r = {1'b1, 4'd2};
      7'b0000110: r = {1'b1, 4'd3};
      7'b1001100: r = {1'b1, 4'd4};
      7'b0100100: r = {1'b1, 4'd5};
      7'b0100000: r = {1'b1, 4'd6};
      7'b0001111: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0000100: r = {1'b1, 4'd9};
      default:    r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  logic [4:0] dec_tens;
  logic [4:0] dec_ones;
  logic [6:0] value;
  logic [6:0] expected_val;
  logic       dp_ok;
  logic       code_ok;
  logic       step_match;

  assign dec_tens = decode_digit(seg_tens[7:1]);
  assign dec_ones = decode_digit(seg_ones[7:1]);
  assign value    = {3'b000, dec_tens[3:0]} * 7'd10 + {3'b000, dec_ones[3:0]};

`ifdef DP_CHECK_EN
  assign dp_ok = seg_tens[0] & seg_ones[0];
`else
  logic unused_dp;
  assign unused_dp = seg_tens[0] ^ seg_ones[0];
  assign dp_ok     = 1'b1;
`endif

  assign code_ok      = dec_tens[4] & dec_ones[4] & (value <= START_V) & dp_ok;
  assign expected_val = (prev_val == 7'd0) ? WRAP_V : prev_val - 7'd1;
  assign step_match   = (value == expected_val);

  // Sequence tracker; every output is registered and pulses clear each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      prev_val  <= '0;
      match_cnt <= '0;
      tens      <= '0;
      ones      <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      code_err  <= 1'b0;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      code_err <= 1'b0;
      seq_err  <= 1'b0;
      wrap     <= 1'b0;
      if (sample) begin
        if (!code_ok) begin
          // Displayed digits are kept so the last good value stays visible.
          code_err  <= 1'b1;
          valid     <= 1'b0;
          locked    <= 1'b0;
          state     <= HUNT;
          match_cnt <= '0;
          err_cnt   <= (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
        end else begin
          tens     <= dec_tens[3:0];
          ones     <= dec_ones[3:0];
          valid    <= 1'b1;
          prev_val <= value;
          case (state)
            HUNT: begin
              state     <= TRACK;
              match_cnt <= '0;
            end
            TRACK: begin
              if (step_match) begin
                if (match_cnt + 4'd1 == LOCK_V) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
                match_cnt <= match_cnt + 4'd1;
              end else begin
                seq_err   <= 1'b1;
                match_cnt <= '0;
                err_cnt   <= (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
              end
            end
            LOCKED: begin
              if (step_match) begin
                wrap <= (prev_val == 7'd0);
              end else begin
                seq_err   <= 1'b1;
                state     <= TRACK;
                locked    <= 1'b0;
                match_cnt <= '0;
                err_cnt   <= (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
              end
            end
            default: begin
              state     <= HUNT;
              locked    <= 1'b0;
              match_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_countdown_monitor.sv
// Scoreboard bench for ssd_countdown_monitor: directed display values in, expected results queued and checked by a monitor.
module tb_ssd_countdown_monitor;

`ifdef DP_CHECK_EN
  localparam bit DP = 1'b1;
`else
  localparam bit DP = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] o;
    logic       v;
    logic       l;
    logic       ce;
    logic       se;
    logic       w;
    logic [7:0] ec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg_tens;
  logic [7:0] seg_ones;
  logic       sample;
  logic [3:0] tens, ones;
  logic       valid, locked, code_err, seq_err, wrap;
  logic [7:0] err_cnt;

  logic [3:0] unused_tens2, unused_ones2;
  logic       unused_valid2, unused_locked2, unused_ce2, unused_se2, unused_wrap2;
  logic [1:0] err_cnt2;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  logic was_sample = 1'b0;
  logic was_rst = 1'b0;
  logic armed = 1'b0;

  always #5 clk = ~clk;

  ssd_countdown_monitor dut (
    .clk(clk), .rst(rst), .seg_tens(seg_tens), .seg_ones(seg_ones), .sample(sample),
    .tens(tens), .ones(ones), .valid(valid), .locked(locked), .code_err(code_err),
    .seq_err(seq_err), .wrap(wrap), .err_cnt(err_cnt)
  );

  ssd_countdown_monitor #(.ERR_W(2)) dut_small (
    .clk(clk), .rst(rst), .seg_tens(seg_tens), .seg_ones(seg_ones), .sample(sample),
    .tens(unused_tens2), .ones(unused_ones2), .valid(unused_valid2), .locked(unused_locked2),
    .code_err(unused_ce2), .seq_err(unused_se2), .wrap(unused_wrap2), .err_cnt(err_cnt2)
  );

  function automatic logic [7:0] seg(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'b0000001;  1: p = 7'b1001111;  2: p = 7'b0010010;
      3: p = 7'b0000110;  4: p = 7'b1001100;  5: p = 7'b0100100;
      6: p = 7'b0100000;  7: p = 7'b0001111;  8: p = 7'b0000000;
      default: p = 7'b0000100;
    endcase
    return {p, 1'b1};
  endfunction

  function automatic exp_t mk(input int t, o, input bit v, l, ce, se, w, input int ec);
    exp_t e;
    e.t = 4'(t); e.o = 4'(o); e.v = v; e.l = l; e.ce = ce; e.se = se; e.w = w; e.ec = 8'(ec);
    return e;
  endfunction

  task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    else passed++;
  endtask

  task automatic check_output();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_field("queue_underflow", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check_field("tens", tens, e.t);
    check_field("ones", ones, e.o);
    check_field("valid", valid, e.v);
    check_field("locked", locked, e.l);
    check_field("code_err", code_err, e.ce);
    check_field("seq_err", seq_err, e.se);
    check_field("wrap", wrap, e.w);
    check_field("err_cnt", err_cnt, e.ec);
    check_field("err_cnt_sat", err_cnt2, (e.ec > 3) ? 3 : e.ec);
  endtask

  always @(posedge clk) begin
    was_sample = sample;
    was_rst    = rst;
  end

  // Outputs change only on posedge, so the negedge sees the result of the last edge.
  always @(negedge clk) begin
    if (armed) begin
      if (was_sample || was_rst) check_output();
      else check_field("idle_pulses", {code_err, seq_err, wrap}, 0);
    end
  end

  // Called at a negedge; leaves the bench at a negedge.
  task automatic apply_stimulus(input logic [7:0] ts, input logic [7:0] os, input exp_t e, input int gap);
    seg_tens = ts;
    seg_ones = os;
    sample   = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    sample = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send(input int t, input int o, input exp_t e, input int gap);
    apply_stimulus(seg(t), seg(o), e, gap);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int eb;
    rst = 1'b0; sample = 1'b0; seg_tens = 8'hFF; seg_ones = 8'hFF;
    @(negedge clk);
    rst = 1'b1; armed = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send(3, 0, mk(3, 0, 1, 0, 0, 0, 0, 0), 3);
    send(2, 9, mk(2, 9, 1, 0, 0, 0, 0, 0), 3);
    send(2, 8, mk(2, 8, 1, 0, 0, 0, 0, 0), 3);
    send(2, 7, mk(2, 7, 1, 1, 0, 0, 0, 0), 3);
    for (int d = 26; d >= 0; d--) send(d / 10, d % 10, mk(d / 10, d % 10, 1, 1, 0, 0, 0, 0), 3);
    send(2, 9, mk(2, 9, 1, 1, 0, 0, 1, 0), 3);

    send(2, 5, mk(2, 5, 1, 0, 0, 1, 0, 1), 3);
    send(2, 4, mk(2, 4, 1, 0, 0, 0, 0, 1), 3);
    send(2, 3, mk(2, 3, 1, 0, 0, 0, 0, 1), 3);
    send(2, 2, mk(2, 2, 1, 1, 0, 0, 0, 1), 3);

    apply_stimulus(seg(2), 8'b01110001, mk(2, 2, 0, 0, 1, 0, 0, 2), 3);
    send(4, 5, mk(2, 2, 0, 0, 1, 0, 0, 3), 3);
    send(1, 0, mk(1, 0, 1, 0, 0, 0, 0, 3), 3);
    send(1, 0, mk(1, 0, 1, 0, 0, 1, 0, 4), 3);
    send(9, 9, mk(1, 0, 0, 0, 1, 0, 0, 5), 3);
    apply_stimulus(8'hFF, seg(3), mk(1, 0, 0, 0, 1, 0, 0, 6), 3);

    if (DP) begin
      apply_stimulus(seg(2) & 8'hFE, seg(9) & 8'hFE, mk(1, 0, 0, 0, 1, 0, 0, 7), 3);
      eb = 7;
    end else begin
      apply_stimulus(seg(2) & 8'hFE, seg(9) & 8'hFE, mk(2, 9, 1, 0, 0, 0, 0, 6), 3);
      eb = 6;
    end
    send(2, 8, mk(2, 8, 1, 0, 0, 0, 0, eb), 3);
    send(2, 7, mk(2, 7, 1, 0, 0, 0, 0, eb), 0);
    send(2, 6, mk(2, 6, 1, !DP, 0, 0, 0, eb), 0);
    send(2, 5, mk(2, 5, 1, 1, 0, 0, 0, eb), 3);

    rst = 1'b1; sample = 1'b1; seg_tens = seg(2); seg_ones = seg(4);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0; sample = 1'b0;
    repeat (2) @(negedge clk);
    send(2, 3, mk(2, 3, 1, 0, 0, 0, 0, 0), 3);
    send(2, 2, mk(2, 2, 1, 0, 0, 0, 0, 0), 3);

    repeat (4) @(negedge clk);
    check_field("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
